// File: rtl/johnson_decoder.sv
// Johnson-code position decoder: validates each sampled code, converts it to a binary
// position, and tracks step direction, lock status and the signed net wrap count.
module johnson_decoder #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8,
  localparam int IDX_W = $clog2(2 * WIDTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  code_in,
  input  logic              code_valid,
  input  logic              clear_err,
  output logic [IDX_W-1:0]  index,
  output logic              dir,
  output logic              step,
  output logic              illegal,
  output logic              err_sticky,
  output logic              locked,
  output logic [WRAP_W-1:0] wrap_count
);

  localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(2 * WIDTH - 1);
  localparam logic signed [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  // A Johnson code read MSB..LSB has at most one 0/1 boundary.
  function automatic logic is_legal(input logic [WIDTH-1:0] c);
    int t;
    t = 0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (c[i] != c[i+1]) t++;
    end
    return (t <= 1);
  endfunction

  function automatic logic [IDX_W-1:0] decode(input logic [WIDTH-1:0] c);
    int pop;
    pop = 0;
    for (int i = 0; i < WIDTH; i++) pop += int'(c[i]);
    if (c[0] || (c == '0)) return IDX_W'(pop);
    return IDX_W'(2 * WIDTH - pop);
  endfunction

  // Stage p0: combinational legality check, decode and neighbour positions.
  logic                      legal_p0;
  logic [IDX_W-1:0]          idx_p0;
  logic [IDX_W-1:0]          nxt_p0;
  logic [IDX_W-1:0]          prv_p0;

  state_t                    state_p1;
  logic [IDX_W-1:0]          index_p1;
  logic                      dir_p1;
  logic                      step_p1;
  logic                      illegal_p1;
  logic                      err_p1;
  logic                      locked_p1;
  logic signed [WRAP_W-1:0]  wrap_p1;

  assign legal_p0 = is_legal(code_in);
  assign idx_p0   = decode(code_in);
  assign nxt_p0   = (index_p1 == LAST_IDX) ? '0 : index_p1 + 1'b1;
  assign prv_p0   = (index_p1 == '0) ? LAST_IDX : index_p1 - 1'b1;

  // Stage p1: registered state and outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_p1   <= UNLOCKED;
      index_p1   <= '0;
      dir_p1     <= 1'b0;
      step_p1    <= 1'b0;
      illegal_p1 <= 1'b0;
      err_p1     <= 1'b0;
      locked_p1  <= 1'b0;
      wrap_p1    <= '0;
    end else begin
      step_p1    <= 1'b0;
      illegal_p1 <= 1'b0;
      if (clear_err) err_p1 <= 1'b0;
      if (code_valid) begin
        case (state_p1)
          UNLOCKED: begin
            if (legal_p0) begin
              index_p1  <= idx_p0;
              locked_p1 <= 1'b1;
              state_p1  <= LOCKED;
            end else begin
              illegal_p1 <= 1'b1;
              err_p1     <= 1'b1;
            end
          end
          LOCKED: begin
            if (legal_p0 && (idx_p0 == index_p1)) begin
              // Same position re-sampled: nothing to report.
            end else if (legal_p0 && (idx_p0 == nxt_p0)) begin
              index_p1 <= idx_p0;
              step_p1  <= 1'b1;
              dir_p1   <= 1'b1;
              if (index_p1 == LAST_IDX) wrap_p1 <= wrap_p1 + WRAP_ONE;
            end else if (legal_p0 && (idx_p0 == prv_p0)) begin
              index_p1 <= idx_p0;
              step_p1  <= 1'b1;
              dir_p1   <= 1'b0;
              if (index_p1 == '0) wrap_p1 <= wrap_p1 - WRAP_ONE;
            end else begin
              // Illegal code or a jump: keep the last good index, drop lock.
              illegal_p1 <= 1'b1;
              err_p1     <= 1'b1;
              locked_p1  <= 1'b0;
              state_p1   <= UNLOCKED;
            end
          end
          default: state_p1 <= UNLOCKED;
        endcase
      end
    end
  end

  assign index      = index_p1;
  assign dir        = dir_p1;
  assign step       = step_p1;
  assign illegal    = illegal_p1;
  assign err_sticky = err_p1;
  assign locked     = locked_p1;
  assign wrap_count = wrap_p1;

endmodule

// File: tb/tb_johnson_decoder.sv
// Scoreboard bench for johnson_decoder (WIDTH=4, WRAP_W=8) using directed vectors
// with hand-computed expected outputs.
module tb_johnson_decoder;

  logic       clock;
  logic       reset;
  logic [3:0] code_in;
  logic       code_valid;
  logic       clear_err;
  logic [2:0] index;
  logic       dir;
  logic       step;
  logic       illegal;
  logic       err_sticky;
  logic       locked;
  logic [7:0] wrap_count;

  johnson_decoder #(.WIDTH(4), .WRAP_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .code_in    (code_in),
    .code_valid (code_valid),
    .clear_err  (clear_err),
    .index      (index),
    .dir        (dir),
    .step       (step),
    .illegal    (illegal),
    .err_sticky (err_sticky),
    .locked     (locked),
    .wrap_count (wrap_count)
  );

  typedef struct {
    string      tag;
    logic [2:0] idx;
    logic       dir;
    logic       step;
    logic       ill;
    logic       err;
    logic       lock;
    logic [7:0] wrap;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input int idx, input int d, input int s,
                              input int il, input int er, input int lk, input int wr);
    exp_t e;
    e.tag  = tag;
    e.idx  = 3'(idx);
    e.dir  = 1'(d);
    e.step = 1'(s);
    e.ill  = 1'(il);
    e.err  = 1'(er);
    e.lock = 1'(lk);
    e.wrap = 8'(wr);
    return e;
  endfunction

  // Monitor: one expectation per driven sample, checked after the edge that consumes it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.tag, ".index"},   int'(index),      int'(e.idx));
        chk({e.tag, ".dir"},     int'(dir),        int'(e.dir));
        chk({e.tag, ".step"},    int'(step),       int'(e.step));
        chk({e.tag, ".illegal"}, int'(illegal),    int'(e.ill));
        chk({e.tag, ".err"},     int'(err_sticky), int'(e.err));
        chk({e.tag, ".locked"},  int'(locked),     int'(e.lock));
        chk({e.tag, ".wrap"},    int'(wrap_count), int'(e.wrap));
      end
    end
  end

  task automatic drive(input logic [3:0] c, input logic v, input logic clr, input exp_t e);
    @(negedge clock);
    code_in    = c;
    code_valid = v;
    clear_err  = clr;
    sb.push_back(e);
    @(posedge clock);
    #1;
    code_valid = 1'b0;
    clear_err  = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".index"},   int'(index),      0);
    chk({tag, ".dir"},     int'(dir),        0);
    chk({tag, ".step"},    int'(step),       0);
    chk({tag, ".illegal"}, int'(illegal),    0);
    chk({tag, ".err"},     int'(err_sticky), 0);
    chk({tag, ".locked"},  int'(locked),     0);
    chk({tag, ".wrap"},    int'(wrap_count), 0);
  endtask

  task automatic reset_dut();
    repeat (2) @(negedge clock);
    code_valid = 1'b0;
    clear_err  = 1'b0;
    reset      = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq [8];
    seq[0] = 4'b0000; seq[1] = 4'b0001; seq[2] = 4'b0011; seq[3] = 4'b0111;
    seq[4] = 4'b1111; seq[5] = 4'b1110; seq[6] = 4'b1100; seq[7] = 4'b1000;

    reset      = 1'b1;
    code_in    = 4'b0000;
    code_valid = 1'b0;
    clear_err  = 1'b0;
    repeat (2) @(negedge clock);
    check_zero("reset");
    reset = 1'b0;

    // Two full laps upward; wrap_count increments on each 1000 -> 0000.
    drive(4'b0000, 1'b1, 1'b0, mk("t1_lock", 0, 0, 0, 0, 0, 1, 0));
    for (int k = 1; k <= 16; k++)
      drive(seq[k % 8], 1'b1, 1'b0, mk($sformatf("t1_up%0d", k), k % 8, 1, 1, 0, 0, 1, k / 8));

    // Downward across zero.
    reset_dut();
    drive(4'b0000, 1'b1, 1'b0, mk("t2_lock", 0, 0, 0, 0, 0, 1, 0));
    drive(4'b1000, 1'b1, 1'b0, mk("t2_dn7", 7, 0, 1, 0, 0, 1, 8'hFF));
    drive(4'b1100, 1'b1, 1'b0, mk("t2_dn6", 6, 0, 1, 0, 0, 1, 8'hFF));

    // Illegal code while locked, then relock.
    reset_dut();
    drive(4'b0011, 1'b1, 1'b0, mk("t3_lock",  2, 0, 0, 0, 0, 1, 0));
    drive(4'b0101, 1'b1, 1'b0, mk("t3_bad",   2, 0, 0, 1, 1, 0, 0));
    drive(4'b0111, 1'b1, 1'b0, mk("t3_relock", 3, 0, 0, 0, 1, 1, 0));

    // Non-adjacent jump, then clear_err priority.
    reset_dut();
    drive(4'b0001, 1'b1, 1'b0, mk("t4_lock",    1, 0, 0, 0, 0, 1, 0));
    drive(4'b0111, 1'b1, 1'b0, mk("t4_jump",    1, 0, 0, 1, 1, 0, 0));
    drive(4'b0101, 1'b1, 1'b1, mk("t4_clr_set", 1, 0, 0, 1, 1, 0, 0));
    drive(4'b0101, 1'b0, 1'b1, mk("t4_clr",     1, 0, 0, 0, 0, 0, 0));
    drive(4'b0011, 1'b1, 1'b0, mk("t4_relock",  2, 0, 0, 0, 0, 1, 0));

    // Hold on repeated code; invalid samples are ignored.
    reset_dut();
    drive(4'b1110, 1'b1, 1'b0, mk("t5_lock", 5, 0, 0, 0, 0, 1, 0));
    drive(4'b1110, 1'b1, 1'b0, mk("t5_hold", 5, 0, 0, 0, 0, 1, 0));
    drive(4'b0101, 1'b0, 1'b0, mk("t5_nv0",  5, 0, 0, 0, 0, 1, 0));
    drive(4'b1010, 1'b0, 1'b0, mk("t5_nv1",  5, 0, 0, 0, 0, 1, 0));
    drive(4'b0110, 1'b0, 1'b0, mk("t5_nv2",  5, 0, 0, 0, 0, 1, 0));
    drive(4'b0000, 1'b0, 1'b0, mk("t5_nv3",  5, 0, 0, 0, 0, 1, 0));
    drive(4'b1100, 1'b1, 1'b0, mk("t5_up6",  6, 1, 1, 0, 0, 1, 0));
    drive(4'b1000, 1'b1, 1'b0, mk("t5_up7",  7, 1, 1, 0, 0, 1, 0));

    // Asynchronous reset between edges, then relock without a step.
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check_zero("t6_async");
    @(negedge clock);
    reset = 1'b0;
    drive(4'b1110, 1'b1, 1'b0, mk("t6_relock", 5, 0, 0, 0, 0, 1, 0));

    repeat (3) @(negedge clock);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
